// File: rtl/or1200_wbforw_if.sv
// Operand-forwarding bundle between the ID/EX/WB datapath and the
// writeback/forwarding control block.
interface or1200_wbforw_if #(
  parameter int width = 32
);
  logic             id_freeze;
  logic             ex_freeze;
  logic             wb_freeze;
  logic [4:0]       id_addra;
  logic [4:0]       id_addrb;
  logic             id_sel_imm;
  logic             id_rfwb;
  logic [4:0]       id_addrw;
  logic             id_load;
  logic [1:0]       id_wbsrc;
  logic [width-1:0] alu_result;
  logic [width-1:0] spr_dataout;
  logic [31:0]      ex_pc;
  logic [width-1:0] lsu_dataout;
  logic [width-1:0] ex_forw;
  logic [width-1:0] wb_forw;
  logic             rf_we;
  logic [4:0]       rf_addrw;
  logic [width-1:0] rf_dataw;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic             lu_stall;

  modport master (
    output id_freeze, ex_freeze, wb_freeze,
    output id_addra, id_addrb, id_sel_imm,
    output id_rfwb, id_addrw, id_load, id_wbsrc,
    output alu_result, spr_dataout, ex_pc,
    output lsu_dataout,
    input  ex_forw, wb_forw,
    input  rf_we, rf_addrw, rf_dataw,
    input  sel_a, sel_b, lu_stall
  );

  modport slave (
    input  id_freeze, ex_freeze, wb_freeze,
    input  id_addra, id_addrb, id_sel_imm,
    input  id_rfwb, id_addrw, id_load, id_wbsrc,
    input  alu_result, spr_dataout, ex_pc,
    input  lsu_dataout,
    output ex_forw, wb_forw,
    output rf_we, rf_addrw, rf_dataw,
    output sel_a, sel_b, lu_stall
  );
endinterface

// File: rtl/or1200_wbforw.sv
// OR1200 writeback and forwarding control: tracks EX/WB destinations,
// drives forwarding buses, operand selects, RF write port, load-use stall.
module or1200_wbforw #(
  parameter int width = 32
) (
  input logic clk,
  input logic rst,
  or1200_wbforw_if.slave fw
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_EX  = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  logic             r_ex_v;
  logic [4:0]       r_ex_addrw;
  logic             r_ex_load;
  logic [1:0]       r_ex_wbsrc;
  logic             r_wb_v;
  logic [4:0]       r_wb_addrw;
  logic             r_wb_load;
  logic [width-1:0] r_wb_res;

  logic [31:0]      w_link;
  logic [width-1:0] w_ex_forw;
  logic [width-1:0] w_wb_forw;
  logic             w_mex_a;
  logic             w_mex_b;
  logic             w_mwb_a;
  logic             w_mwb_b;
  logic             w_lu;

  assign w_link = fw.ex_pc + 32'd8;

  always_comb begin
    w_ex_forw = '0;
    unique case (r_ex_wbsrc)
      2'd0: w_ex_forw = fw.alu_result;
      2'd1: w_ex_forw = '0;
      2'd2: w_ex_forw = fw.spr_dataout;
      2'd3: w_ex_forw = width'(w_link);
    endcase
  end

  assign w_wb_forw = r_wb_load ? fw.lsu_dataout : r_wb_res;

  // R0 is hard-wired zero, so it never matches a producer
  assign w_mex_a = r_ex_v && (r_ex_addrw == fw.id_addra)
                && (fw.id_addra != 5'd0);
  assign w_mex_b = r_ex_v && (r_ex_addrw == fw.id_addrb)
                && (fw.id_addrb != 5'd0);
  assign w_mwb_a = r_wb_v && (r_wb_addrw == fw.id_addra)
                && (fw.id_addra != 5'd0);
  assign w_mwb_b = r_wb_v && (r_wb_addrw == fw.id_addrb)
                && (fw.id_addrb != 5'd0);

  assign w_lu = r_ex_load
             && (w_mex_a || (!fw.id_sel_imm && w_mex_b));

  always_comb begin
    fw.sel_a = SEL_RF;
    if (w_mex_a)
      fw.sel_a = SEL_EX;
    else if (w_mwb_a)
      fw.sel_a = SEL_WB;
  end

  always_comb begin
    fw.sel_b = SEL_RF;
    if (fw.id_sel_imm)
      fw.sel_b = SEL_IMM;
    else if (w_mex_b)
      fw.sel_b = SEL_EX;
    else if (w_mwb_b)
      fw.sel_b = SEL_WB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_v     <= 1'b0;
      r_ex_addrw <= '0;
      r_ex_load  <= 1'b0;
      r_ex_wbsrc <= '0;
    end else if (!fw.ex_freeze) begin
      if (fw.id_freeze || w_lu) begin
        r_ex_v     <= 1'b0;
        r_ex_addrw <= '0;
        r_ex_load  <= 1'b0;
        r_ex_wbsrc <= '0;
      end else begin
        r_ex_v     <= fw.id_rfwb;
        r_ex_addrw <= fw.id_addrw;
        r_ex_load  <= fw.id_load;
        r_ex_wbsrc <= fw.id_wbsrc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_v     <= 1'b0;
      r_wb_addrw <= '0;
      r_wb_load  <= 1'b0;
      r_wb_res   <= '0;
    end else if (!fw.wb_freeze) begin
      if (fw.ex_freeze) begin
        r_wb_v     <= 1'b0;
        r_wb_addrw <= '0;
        r_wb_load  <= 1'b0;
        r_wb_res   <= '0;
      end else begin
        r_wb_v     <= r_ex_v;
        r_wb_addrw <= r_ex_addrw;
        r_wb_load  <= r_ex_load;
        r_wb_res   <= w_ex_forw;
      end
    end
  end

  assign fw.ex_forw  = w_ex_forw;
  assign fw.wb_forw  = w_wb_forw;
  assign fw.rf_dataw = w_wb_forw;
  assign fw.rf_addrw = r_wb_addrw;
  // a frozen WB slot writes once, on its first unfrozen cycle
  assign fw.rf_we    = r_wb_v && (r_wb_addrw != 5'd0) && !fw.wb_freeze;
  assign fw.lu_stall = w_lu;

endmodule
